// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with first-word-fall-through read port and
// occupancy flags. Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int ADDR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_EN
    ,
    input  logic                  err_clear,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AFULL_T  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_T = AEMPTY_THRESH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   write_ptr;
    logic [ADDR_WIDTH:0]   read_ptr;
    logic                  rd_ok;
    logic                  wr_ok;

    // Accepting a read frees a slot, so a full FIFO still takes a same-cycle write.
    always_comb begin
        rd_ok = read_en && !empty;
        wr_ok = write_en && (!full || rd_ok);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[write_ptr[ADDR_WIDTH-1:0]] <= write_data;
                write_ptr <= write_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                read_ptr <= read_ptr + PTR_ONE;
            end
        end
    end

    // All outputs decode from registered pointers; the extra wrap bit separates full from empty.
    always_comb begin
        empty        = (write_ptr == read_ptr);
        full         = (write_ptr[ADDR_WIDTH] != read_ptr[ADDR_WIDTH]) &&
                       (write_ptr[ADDR_WIDTH-1:0] == read_ptr[ADDR_WIDTH-1:0]);
        count        = write_ptr - read_ptr;
        almost_full  = (count >= AFULL_T);
        almost_empty = (count <= AEMPTY_T);
        read_data    = mem[read_ptr[ADDR_WIDTH-1:0]];
    end

`ifdef SYNC_FIFO_ERR_EN
    // Set has priority over clear so an error coinciding with err_clear is kept.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (err_clear) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (write_en && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at DATA_WIDTH=8, DEPTH=8.
// Error-flag checks are included when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo_param;

    logic       clk;
    logic       rstN;
    logic       write_en;
    logic [7:0] write_data;
    logic       read_en;
    logic [7:0] read_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
`ifdef SYNC_FIFO_ERR_EN
    logic       err_clear;
    logic       overflow;
    logic       underflow;
`endif

    int n_checks;
    int n_bad;
    logic [7:0] model_q [$];

    sync_fifo_param #(
        .DATA_WIDTH(8),
        .DEPTH     (8)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .write_en    (write_en),
        .write_data  (write_data),
        .read_en     (read_en),
        .read_data   (read_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .err_clear   (err_clear),
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic ec);
        write_en   = we;
        write_data = wd;
        read_en    = re;
`ifdef SYNC_FIFO_ERR_EN
        err_clear  = ec;
`else
        if (ec) begin
            write_en = we;
        end
`endif
        @(posedge clk);
        #1;
        write_en   = 1'b0;
        read_en    = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        err_clear  = 1'b0;
`endif
    endtask

    initial begin
        n_checks   = 0;
        n_bad      = 0;
        rstN       = 1'b0;
        write_en   = 1'b0;
        write_data = 8'h00;
        read_en    = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        err_clear  = 1'b0;
`endif
        #12;
        check_eq("rst_empty",  32'(empty), 32'd1);
        check_eq("rst_full",   32'(full), 32'd0);
        check_eq("rst_count",  32'(count), 32'd0);
        check_eq("rst_af",     32'(almost_full), 32'd0);
        check_eq("rst_ae",     32'(almost_empty), 32'd1);
        check_eq("rst_rdata",  32'(read_data), 32'h00);
        rstN = 1'b1;

        // Fill 0x10..0x17; first edge after reset release accepts a write.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            check_eq("fill_count", 32'(count), 32'(i + 1));
            check_eq("fill_af",    32'(almost_full), (i + 1 >= 7) ? 32'd1 : 32'd0);
            check_eq("fill_full",  32'(full), (i == 7) ? 32'd1 : 32'd0);
            if (i == 0) begin
                check_eq("fwft_rdata", 32'(read_data), 32'h10);
                check_eq("fill_empty", 32'(empty), 32'd0);
            end
        end

        // Write while full with no read is dropped.
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check_eq("ovf_count", 32'(count), 32'd8);
        check_eq("ovf_head",  32'(read_data), 32'h10);

        // Full boundary: simultaneous read and write.
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check_eq("fb_count", 32'(count), 32'd8);
        check_eq("fb_full",  32'(full), 32'd1);
        for (int k = 1; k < 8; k++) begin
            check_eq("fb_data", 32'(read_data), 32'(8'h10 + k));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_eq("fb_data_aa", 32'(read_data), 32'hAA);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("drain_empty", 32'(empty), 32'd1);
        check_eq("drain_count", 32'(count), 32'd0);
        check_eq("drain_ae",    32'(almost_empty), 32'd1);

        // Read while empty is ignored.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("udf_count", 32'(count), 32'd0);

        // Empty boundary: read rejected, write accepted.
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check_eq("eb_count", 32'(count), 32'd1);
        check_eq("eb_empty", 32'(empty), 32'd0);
        check_eq("eb_rdata", 32'(read_data), 32'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("eb_drain", 32'(empty), 32'd1);

        // Wrap-around at constant occupancy 3.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
            model_q.push_back(8'(8'h60 + i));
        end
        for (int i = 0; i < 20; i++) begin
            check_eq("wrap_data", 32'(read_data), 32'(model_q[0]));
            step(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
            void'(model_q.pop_front());
            model_q.push_back(8'(8'h70 + i));
            check_eq("wrap_count", 32'(count), 32'd3);
            check_eq("wrap_full",  32'(full), 32'd0);
        end

        // Asynchronous reset mid-stream at count 5.
        step(1'b1, 8'h90, 1'b0, 1'b0);
        step(1'b1, 8'h91, 1'b0, 1'b0);
        check_eq("pre_rst_count", 32'(count), 32'd5);
        #2;
        rstN = 1'b0;
        #1;
        check_eq("mrst_count", 32'(count), 32'd0);
        check_eq("mrst_empty", 32'(empty), 32'd1);
        check_eq("mrst_full",  32'(full), 32'd0);
        check_eq("mrst_af",    32'(almost_full), 32'd0);
        check_eq("mrst_ae",    32'(almost_empty), 32'd1);
        check_eq("mrst_rdata", 32'(read_data), 32'h00);
        @(posedge clk);
        #1;
        rstN = 1'b1;

`ifdef SYNC_FIFO_ERR_EN
        check_eq("err_ovf_rst", 32'(overflow), 32'd0);
        check_eq("err_udf_rst", 32'(underflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check_eq("err_ovf_set",   32'(overflow), 32'd1);
        check_eq("err_ovf_count", 32'(count), 32'd8);
        check_eq("err_ovf_head",  32'(read_data), 32'hA0);
        step(1'b1, 8'hEF, 1'b0, 1'b1);
        check_eq("err_ovf_keep",  32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("err_ovf_clr",   32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check_eq("err_drain", 32'(read_data), 32'(8'hA0 + i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_eq("err_udf_pre",   32'(underflow), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("err_udf_set",   32'(underflow), 32'd1);
        check_eq("err_udf_count", 32'(count), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("err_udf_clr",   32'(underflow), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
